// File: rtl/bcd_field_counter.sv
// One BCD time field (seconds/minutes/hours...): run-mode counting with cascade carry,
// set-mode inc/dec editing, parallel load and a blink phase for the display.

module bcd_digit (
    input  logic [3:0] d,
    input  logic       cin,
    input  logic       bin,
    output logic [3:0] d_inc,
    output logic [3:0] d_dec,
    output logic       cout,
    output logic       bout
);
    always_comb begin
        d_inc = d;
        d_dec = d;
        cout  = 1'b0;
        bout  = 1'b0;
        if (cin) begin
            cout  = (d == 4'd9);
            d_inc = (d == 4'd9) ? 4'd0 : d + 4'd1;
        end
        if (bin) begin
            bout  = (d == 4'd0);
            d_dec = (d == 4'd0) ? 4'd9 : d - 4'd1;
        end
    end
endmodule

module bcd_field_counter #(
    parameter int DIGITS  = 2,
    parameter int MAX_VAL = 59
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  tick_en,
    input  logic                  set_mode,
    input  logic                  sel,
    input  logic                  inc_p,
    input  logic                  dec_p,
    input  logic                  blink_tick,
    input  logic                  load_en,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  carry,
    output logic                  blank
);
    localparam int W = 4*DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic is_bcd(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

    generate
        if (DIGITS < 1 || MAX_VAL < 1 || MAX_VAL > 10**DIGITS - 1) begin : g_bad_param
            $error("bcd_field_counter: MAX_VAL out of range for DIGITS");
        end
    endgenerate

    // Ripple increment/decrement chains; the last borrow-out doubles as the zero detect.
    logic [DIGITS:0] ic, bc;
    logic [W-1:0]    cnt_inc_raw, cnt_dec_raw;
    assign ic[0] = 1'b1;
    assign bc[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_digit u_dig (
                .d     (cnt[4*g +: 4]),
                .cin   (ic[g]),
                .bin   (bc[g]),
                .d_inc (cnt_inc_raw[4*g +: 4]),
                .d_dec (cnt_dec_raw[4*g +: 4]),
                .cout  (ic[g+1]),
                .bout  (bc[g+1])
            );
        end
    endgenerate

    logic         cnt_ok, at_max, load_ok;
    logic [W-1:0] inc_nxt, dec_nxt;

    always_comb begin
        cnt_ok  = is_bcd(cnt) && (cnt <= MAX_BCD);
        at_max  = (cnt == MAX_BCD);
        load_ok = is_bcd(load_val) && (load_val <= MAX_BCD);
        // Out-of-range contents recover to 0 on increment and MAX_VAL on decrement.
        inc_nxt = (!cnt_ok || at_max || ic[DIGITS]) ? '0 : cnt_inc_raw;
        dec_nxt = (!cnt_ok || bc[DIGITS]) ? MAX_BCD : cnt_dec_raw;
    end

    // blank is the blink phase register itself.
    always_ff @(posedge clk1) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            blank <= 1'b0;
        end else if (load_en) begin
            cnt   <= load_ok ? load_val : '0;
            carry <= 1'b0;
            blank <= 1'b0;
        end else if (set_mode) begin
            carry <= 1'b0;
            if (!sel) begin
                blank <= 1'b0;
            end else if (inc_p && !dec_p) begin
                cnt   <= inc_nxt;
                blank <= 1'b0;
            end else if (dec_p && !inc_p) begin
                cnt   <= dec_nxt;
                blank <= 1'b0;
            end else if (blink_tick) begin
                blank <= ~blank;
            end
        end else begin
            blank <= 1'b0;
            if (tick_en) begin
                cnt   <= inc_nxt;
                carry <= at_max;
            end else begin
                carry <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bcd_field_counter.sv
// Drives three field configurations (2/59, 2/23, 3/999) with shared controls and
// compares every cycle against a decimal-integer reference model.

module tb_bcd_field_counter;
    logic        clk1 = 1'b0;
    logic        rst, tick_en, set_mode, sel, inc_p, dec_p, blink_tick, load_en;
    logic [7:0]  load_val;
    logic [11:0] load_val3;
    logic [7:0]  cnt_a, cnt_b;
    logic [11:0] cnt_c;
    logic        carry_a, carry_b, carry_c, blank_a, blank_b, blank_c;

    int errors = 0;
    int checks = 0;

    int mx [3] = '{59, 23, 999};
    int v  [3];
    bit c  [3];
    bit ph [3];

    always #5 clk1 = ~clk1;

    bcd_field_counter #(.DIGITS(2), .MAX_VAL(59)) u_dut (
        .clk1(clk1), .rst(rst), .tick_en(tick_en), .set_mode(set_mode), .sel(sel),
        .inc_p(inc_p), .dec_p(dec_p), .blink_tick(blink_tick), .load_en(load_en),
        .load_val(load_val), .cnt(cnt_a), .carry(carry_a), .blank(blank_a));

    bcd_field_counter #(.DIGITS(2), .MAX_VAL(23)) u_hrs (
        .clk1(clk1), .rst(rst), .tick_en(tick_en), .set_mode(set_mode), .sel(sel),
        .inc_p(inc_p), .dec_p(dec_p), .blink_tick(blink_tick), .load_en(load_en),
        .load_val(load_val), .cnt(cnt_b), .carry(carry_b), .blank(blank_b));

    bcd_field_counter #(.DIGITS(3), .MAX_VAL(999)) u_k (
        .clk1(clk1), .rst(rst), .tick_en(tick_en), .set_mode(set_mode), .sel(sel),
        .inc_p(inc_p), .dec_p(dec_p), .blink_tick(blink_tick), .load_en(load_en),
        .load_val(load_val3), .cnt(cnt_c), .carry(carry_c), .blank(blank_c));

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each field is a plain integer in 0..max, edited with decimal arithmetic.
    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                v[k] = 0; c[k] = 0; ph[k] = 0;
            end else if (load_en) begin
                logic [11:0] lv;
                int val;
                bit ok;
                lv  = (k == 2) ? load_val3 : {4'h0, load_val};
                val = 0;
                ok  = 1;
                for (int i = 0; i < 3; i++) begin
                    int d;
                    d = int'(lv[4*i +: 4]);
                    if (d > 9) ok = 0;
                    val += d * ((i == 0) ? 1 : (i == 1) ? 10 : 100);
                end
                v[k]  = (ok && val <= mx[k]) ? val : 0;
                c[k]  = 0;
                ph[k] = 0;
            end else if (set_mode) begin
                c[k] = 0;
                if (!sel) ph[k] = 0;
                else if (inc_p && !dec_p) begin
                    v[k] = (v[k] == mx[k]) ? 0 : v[k] + 1; ph[k] = 0;
                end else if (dec_p && !inc_p) begin
                    v[k] = (v[k] == 0) ? mx[k] : v[k] - 1; ph[k] = 0;
                end else if (blink_tick) ph[k] = !ph[k];
            end else begin
                ph[k] = 0;
                if (tick_en) begin
                    c[k] = (v[k] == mx[k]);
                    v[k] = (v[k] == mx[k]) ? 0 : v[k] + 1;
                end else c[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [11:0] co [3];
        logic        ca [3];
        logic        bl [3];
        co = '{{4'h0, cnt_a}, {4'h0, cnt_b}, cnt_c};
        ca = '{carry_a, carry_b, carry_c};
        bl = '{blank_a, blank_b, blank_c};
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cnt[%0d]", k),   co[k], to_bcd(v[k]));
            chk($sformatf("carry[%0d]", k), {11'h0, ca[k]}, {11'h0, c[k]});
            chk($sformatf("blank[%0d]", k), {11'h0, bl[k]}, {11'h0, ph[k]});
        end
    endtask

    task automatic cyc();
        model_update();
        @(posedge clk1);
        #1;
        check_all();
    endtask

    task automatic idle();
        rst = 0; tick_en = 0; set_mode = 0; sel = 0;
        inc_p = 0; dec_p = 0; blink_tick = 0; load_en = 0;
    endtask

    initial begin
        idle();
        load_val = 8'h00; load_val3 = 12'h000;
        rst = 1; cyc(); cyc(); rst = 0;

        // Run-mode wrap with one-cycle carry
        load_en = 1; load_val = 8'h58; load_val3 = 12'h058; cyc(); load_en = 0;
        tick_en = 1; cyc(); cyc(); tick_en = 0; cyc(); cyc();

        // Set-mode dec/inc wrapping, no carry
        load_en = 1; load_val = 8'h00; load_val3 = 12'h000; cyc(); load_en = 0;
        set_mode = 1; sel = 1;
        dec_p = 1; cyc(); dec_p = 0;
        inc_p = 1; cyc(); inc_p = 0; cyc();

        // Blink phase, edit clears it even with a coincident blink_tick
        blink_tick = 1; cyc(); cyc(); cyc();
        inc_p = 1; cyc(); inc_p = 0; blink_tick = 0; cyc();
        blink_tick = 1; cyc(); blink_tick = 0;
        sel = 0; inc_p = 1; cyc(); inc_p = 0; sel = 1;

        // Ticks ignored in set mode, then resume
        tick_en = 1; repeat (10) cyc();
        set_mode = 0; sel = 0; tick_en = 0; cyc();
        tick_en = 1; cyc(); tick_en = 0; cyc();

        // Loads: illegal BCD, over-range, load wins over tick with no carry
        load_en = 1; load_val = 8'h5A; load_val3 = 12'h5A0; cyc();
        load_val = 8'h42; load_val3 = 12'h420; cyc();
        load_val = 8'h59; load_val3 = 12'h999; tick_en = 1; cyc(); cyc();
        load_en = 0; tick_en = 0; cyc();

        // Three-digit ripple and wrap, then reset mid-edit
        load_en = 1; load_val = 8'h23; load_val3 = 12'h099; cyc(); load_en = 0;
        tick_en = 1; cyc(); tick_en = 0;
        load_en = 1; load_val = 8'h59; load_val3 = 12'h999; cyc(); load_en = 0;
        tick_en = 1; cyc(); tick_en = 0; cyc();
        load_en = 1; load_val = 8'h17; load_val3 = 12'h517; cyc(); load_en = 0;
        set_mode = 1; sel = 1; blink_tick = 1; cyc(); blink_tick = 0;
        rst = 1; inc_p = 1; load_en = 1; tick_en = 1; cyc();
        idle(); cyc();

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            rst        = ($urandom_range(0, 99) == 0);
            load_en    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) begin
                load_val  = 8'(to_bcd($urandom_range(0, 99)));
                load_val3 = to_bcd($urandom_range(0, 999));
            end else begin
                load_val  = 8'($urandom);
                load_val3 = 12'($urandom);
            end
            if ($urandom_range(0, 15) == 0) set_mode = ~set_mode;
            sel        = ($urandom_range(0, 3) != 0);
            tick_en    = $urandom_range(0, 1) == 1;
            inc_p      = ($urandom_range(0, 4) == 0);
            dec_p      = ($urandom_range(0, 4) == 0);
            blink_tick = ($urandom_range(0, 3) == 0);
            if (inc_p && dec_p) blink_tick = 0;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
